// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the read stage and the write-back stage,
// tracks outstanding reads and drops data-phase returns that belong to flushed reads.
module dmem_port_arbiter #(
    parameter int unsigned DDATAW       = 64,
    parameter int unsigned DSIZEW       = 4,
    parameter int unsigned DADDRW       = 32,
    parameter int unsigned MAX_OUTST    = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              rmem_valid,
    output logic              rmem_ready,
    input  logic [DADDRW-1:0] rmem_address,
    output logic              rmem_dp_valid,
    input  logic              rmem_dp_ready,
    output logic [DDATAW-1:0] rmem_dp_read_data,
    input  logic              wmem_valid,
    output logic              wmem_ready,
    input  logic [DADDRW-1:0] wmem_address,
    input  logic [DDATAW-1:0] wmem_wr_data,
    input  logic [DSIZEW-1:0] wmem_wr_size,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DADDRW-1:0] m_address,
    output logic              m_wr_en,
    output logic [DDATAW-1:0] m_wr_data,
    output logic [DSIZEW-1:0] m_wr_size,
    input  logic              m_dp_valid,
    output logic              m_dp_ready,
    input  logic [DDATAW-1:0] m_dp_read_data
);

    localparam int unsigned CNTW = 3;
    localparam int unsigned STW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_R,
        HOLD_W
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   outst_q, outst_d;
    logic [CNTW-1:0]   discard_q, discard_d;
    logic [STW-1:0]    starve_q, starve_d;
    logic              rd_elig;
    logic              rd_gnt;
    logic              wr_gnt;
    logic              rd_hs;
    logic              wr_hs;
    logic              dp_hs;

    // Read data is never buffered; it passes straight through.
    assign rmem_dp_read_data = m_dp_read_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            outst_q   <= '0;
            discard_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            starve_q  <= starve_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        outst_d       = outst_q;
        discard_d     = discard_q;
        starve_d      = starve_q;
        rd_gnt        = 1'b0;
        wr_gnt        = 1'b0;
        m_valid       = 1'b0;
        m_address     = '0;
        m_wr_en       = 1'b0;
        m_wr_data     = '0;
        m_wr_size     = '0;
        rmem_ready    = 1'b0;
        wmem_ready    = 1'b0;
        m_dp_ready    = 1'b0;
        rmem_dp_valid = 1'b0;

        rd_elig = rmem_valid && (outst_q < CNTW'(MAX_OUTST)) && !flush;

        // Writes are older, so they win unless the pending read has starved long enough.
        unique case (state_q)
            IDLE: begin
                if (wmem_valid && ((starve_q < STW'(STARVE_LIMIT)) || !rd_elig)) begin
                    wr_gnt = 1'b1;
                end else if (rd_elig) begin
                    rd_gnt = 1'b1;
                end
            end
            HOLD_R:  rd_gnt = 1'b1;
            HOLD_W:  wr_gnt = 1'b1;
            default: ;
        endcase

        if (!reset) begin
            rd_gnt = 1'b0;
            wr_gnt = 1'b0;
        end

        if (rd_gnt) begin
            m_valid   = rmem_valid;
            m_address = rmem_address;
        end else if (wr_gnt) begin
            m_valid   = wmem_valid;
            m_address = wmem_address;
            m_wr_en   = 1'b1;
            m_wr_data = wmem_wr_data;
            m_wr_size = wmem_wr_size;
        end
        rmem_ready = m_ready && rd_gnt;
        wmem_ready = m_ready && wr_gnt;

        if (state_q == IDLE) begin
            if (m_valid && !m_ready) begin
                state_d = rd_gnt ? HOLD_R : HOLD_W;
            end
        end else if (m_ready) begin
            state_d = IDLE;
        end

        rd_hs = rd_gnt && rmem_valid && m_ready;
        wr_hs = wr_gnt && wmem_valid && m_ready;

        if (discard_q != '0) begin
            m_dp_ready    = reset;
            rmem_dp_valid = 1'b0;
        end else begin
            m_dp_ready    = rmem_dp_ready && reset;
            rmem_dp_valid = m_dp_valid && reset;
        end
        dp_hs = m_dp_valid && m_dp_ready;

        if (rd_hs && !dp_hs) begin
            outst_d = outst_q + CNTW'(1);
        end else if (!rd_hs && dp_hs && (outst_q != '0)) begin
            outst_d = outst_q - CNTW'(1);
        end

        // Everything still in flight after this cycle belongs to the flushed path.
        if (flush) begin
            discard_d = outst_d;
        end else if (dp_hs && (discard_q != '0)) begin
            discard_d = discard_q - CNTW'(1);
        end

        if (rd_hs || !rmem_valid) begin
            starve_d = '0;
        end else if (wr_hs && (starve_q < STW'(STARVE_LIMIT))) begin
            starve_d = starve_q + STW'(1);
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter with a transaction-level reference model.
module tb_dmem_port_arbiter;

    localparam int unsigned DDATAW       = 64;
    localparam int unsigned DSIZEW       = 4;
    localparam int unsigned DADDRW       = 32;
    localparam int unsigned MAX_OUTST    = 4;
    localparam int unsigned STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              rmem_valid;
    logic              rmem_ready;
    logic [DADDRW-1:0] rmem_address;
    logic              rmem_dp_valid;
    logic              rmem_dp_ready;
    logic [DDATAW-1:0] rmem_dp_read_data;
    logic              wmem_valid;
    logic              wmem_ready;
    logic [DADDRW-1:0] wmem_address;
    logic [DDATAW-1:0] wmem_wr_data;
    logic [DSIZEW-1:0] wmem_wr_size;
    logic              m_valid;
    logic              m_ready;
    logic [DADDRW-1:0] m_address;
    logic              m_wr_en;
    logic [DDATAW-1:0] m_wr_data;
    logic [DSIZEW-1:0] m_wr_size;
    logic              m_dp_valid;
    logic              m_dp_ready;
    logic [DDATAW-1:0] m_dp_read_data;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .DDATAW(DDATAW), .DSIZEW(DSIZEW), .DADDRW(DADDRW),
        .MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rmem_valid(rmem_valid), .rmem_ready(rmem_ready), .rmem_address(rmem_address),
        .rmem_dp_valid(rmem_dp_valid), .rmem_dp_ready(rmem_dp_ready),
        .rmem_dp_read_data(rmem_dp_read_data),
        .wmem_valid(wmem_valid), .wmem_ready(wmem_ready), .wmem_address(wmem_address),
        .wmem_wr_data(wmem_wr_data), .wmem_wr_size(wmem_wr_size),
        .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address), .m_wr_en(m_wr_en),
        .m_wr_data(m_wr_data), .m_wr_size(m_wr_size),
        .m_dp_valid(m_dp_valid), .m_dp_ready(m_dp_ready), .m_dp_read_data(m_dp_read_data)
    );

    typedef struct {
        logic [DADDRW-1:0] addr;
        logic [DDATAW-1:0] data;
        logic [DSIZEW-1:0] size;
    } wreq_t;

    typedef struct {
        logic [DDATAW-1:0] data;
        bit                killed;
    } ret_t;

    wreq_t             exp_w[$];
    logic [DADDRW-1:0] exp_r[$];
    logic [DDATAW-1:0] exp_d[$];
    ret_t              mq[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit in_run  = 1'b0;
    bit rd_acc  = 1'b0;
    bit wr_acc  = 1'b0;
    int lock    = 0;
    int wstreak = 0;

    function automatic logic [DDATAW-1:0] rdata(input logic [DADDRW-1:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Monitor and reference model: grant choice, handshake ordering and data-phase fate.
    always @(negedge clk) begin : mon
        int                eg;
        bit                elig;
        bit                rhs;
        bit                whs;
        wreq_t             w;
        logic [DADDRW-1:0] a;
        if (in_run) begin
            if (lock != 0) begin
                eg = lock;
            end else begin
                elig = rmem_valid && (mq.size() < int'(MAX_OUTST)) && !flush;
                if (wmem_valid && ((wstreak < int'(STARVE_LIMIT)) || !elig)) eg = 2;
                else if (elig) eg = 1;
                else eg = 0;
            end
            chk("m_valid", 64'(m_valid), 64'(eg != 0));
            chk("m_wr_en", 64'(m_wr_en), 64'(eg == 2));
            chk("rmem_ready", 64'(rmem_ready), 64'((eg == 1) && m_ready));
            chk("wmem_ready", 64'(wmem_ready), 64'((eg == 2) && m_ready));
            if (eg == 1) begin
                chk("rd_addr_pass", 64'(m_address), 64'(rmem_address));
                chk("rd_wdata_zero", m_wr_data, 64'd0);
                chk("rd_wsize_zero", 64'(m_wr_size), 64'd0);
            end
            whs = (eg == 2) && m_ready;
            rhs = (eg == 1) && m_ready;

            if (m_dp_valid && (mq.size() > 0)) begin
                if (mq[0].killed) begin
                    chk("drop_ready", 64'(m_dp_ready), 64'd1);
                    chk("drop_hidden", 64'(rmem_dp_valid), 64'd0);
                    void'(mq.pop_front());
                end else begin
                    chk("fwd_valid", 64'(rmem_dp_valid), 64'd1);
                    chk("fwd_ready", 64'(m_dp_ready), 64'(rmem_dp_ready));
                    if (exp_d.size() == 0) bad("fwd_no_expected");
                    else chk("fwd_data", rmem_dp_read_data, exp_d[0]);
                    if (rmem_dp_ready) begin
                        void'(mq.pop_front());
                        if (exp_d.size() > 0) void'(exp_d.pop_front());
                    end
                end
            end else begin
                chk("dp_idle", 64'(rmem_dp_valid), 64'd0);
            end

            if (whs) begin
                if (exp_w.size() == 0) bad("w_order");
                else begin
                    w = exp_w.pop_front();
                    chk("w_addr", 64'(m_address), 64'(w.addr));
                    chk("w_data", m_wr_data, w.data);
                    chk("w_size", 64'(m_wr_size), 64'(w.size));
                end
            end
            if (rhs) begin
                if (exp_r.size() == 0) bad("r_order");
                else begin
                    a = exp_r.pop_front();
                    chk("r_addr", 64'(m_address), 64'(a));
                    mq.push_back('{rdata(m_address), 1'b0});
                    exp_d.push_back(rdata(a));
                end
            end
            if (flush) begin
                foreach (mq[i]) mq[i].killed = 1'b1;
                exp_d.delete();
            end

            if (rhs || !rmem_valid) wstreak = 0;
            else if (whs && (wstreak < int'(STARVE_LIMIT))) wstreak++;
            lock   = ((eg != 0) && !m_ready) ? eg : 0;
            rd_acc = rmem_valid && rmem_ready;
            wr_acc = wmem_valid && wmem_ready;
        end
    end

    task automatic drive_cycle(input int pr, input int pw, input int pm,
                               input int pd, input int pq, input int pf);
        @(posedge clk);
        #1;
        if (rmem_valid && rd_acc) rmem_valid = 1'b0;
        if (wmem_valid && wr_acc) wmem_valid = 1'b0;
        if (!rmem_valid && pct(pr)) begin
            rmem_address = $urandom;
            rmem_valid   = 1'b1;
            exp_r.push_back(rmem_address);
        end
        if (!wmem_valid && pct(pw)) begin
            wmem_address = $urandom;
            wmem_wr_data = {$urandom, $urandom};
            wmem_wr_size = DSIZEW'($urandom_range(1, 8));
            wmem_valid   = 1'b1;
            exp_w.push_back('{wmem_address, wmem_wr_data, wmem_wr_size});
        end
        m_ready = pct(pm);
        if ((mq.size() > 0) && pct(pd)) begin
            m_dp_valid     = 1'b1;
            m_dp_read_data = mq[0].data;
        end else begin
            m_dp_valid     = 1'b0;
            m_dp_read_data = {$urandom, $urandom};
        end
        rmem_dp_ready = pct(pq);
        flush         = pct(pf);
    endtask

    initial begin
        reset          = 1'b0;
        flush          = 1'b0;
        rmem_valid     = 1'b1;
        wmem_valid     = 1'b1;
        rmem_address   = 32'h0000_0040;
        wmem_address   = 32'h0000_0080;
        wmem_wr_data   = 64'h1122_3344_5566_7788;
        wmem_wr_size   = 4'd8;
        m_ready        = 1'b1;
        m_dp_valid     = 1'b1;
        m_dp_read_data = 64'h0;
        rmem_dp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_m_valid", 64'(m_valid), 64'd0);
        chk("reset_rmem_ready", 64'(rmem_ready), 64'd0);
        chk("reset_wmem_ready", 64'(wmem_ready), 64'd0);
        chk("reset_rmem_dp_valid", 64'(rmem_dp_valid), 64'd0);
        chk("reset_m_dp_ready", 64'(m_dp_ready), 64'd0);
        chk("reset_m_wr_en", 64'(m_wr_en), 64'd0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        rmem_valid = 1'b0;
        wmem_valid = 1'b0;
        m_dp_valid = 1'b0;
        in_run     = 1'b1;

        // Saturated request traffic with an always-ready port exercises the starvation bound.
        for (int c = 0; c < 1000; c++) drive_cycle(95, 95, 100, 60, 80, 2);
        // General random traffic with request and data-phase backpressure.
        for (int c = 0; c < 1500; c++) drive_cycle(50, 50, 60, 50, 60, 5);
        // Slow returns keep the outstanding limit engaged.
        for (int c = 0; c < 1000; c++) drive_cycle(85, 30, 80, 10, 50, 3);
        // Drain everything still in flight.
        for (int c = 0; c < 300; c++) drive_cycle(0, 0, 100, 100, 100, 0);

        @(negedge clk);
        #1;
        chk("drain_writes", 64'(exp_w.size()), 64'd0);
        chk("drain_reads", 64'(exp_r.size()), 64'd0);
        chk("drain_returns", 64'(mq.size()), 64'd0);
        chk("drain_data", 64'(exp_d.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
